// File: rtl/loop_stream_tx.sv
// loop_stream_tx: 8N1 serial transmitter that drains the cyclic loop buffer one byte per frame.
module loop_stream_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int IDLE_GAP     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  buf_data,
  input  logic        buf_valid,
  output logic        buf_read_en,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [15:0] GAP_LAST = 16'(IDLE_GAP - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [15:0] gap_q, gap_d, cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d, rd_q, rd_d, done_q, done_d;
  logic baud_end;
  assign baud_end = baud_q == BAUD_LAST;
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    baud_d  = (state_q inside {START, DATA, STOP}) && !baud_end ? baud_q + 1'b1 : '0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (enable && buf_valid) begin
          shift_d = buf_data;
          rd_d    = 1'b1;
          tx_d    = 1'b0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: if (baud_end) begin
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        state_d = DATA;
      end
      DATA: if (baud_end) begin
        bit_d   = bit_q + 3'd1;
        tx_d    = (bit_q == 3'd7) ? 1'b1 : shift_q[0];
        shift_d = shift_q >> 1;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (baud_end) begin
        done_d  = 1'b1;
        cnt_d   = cnt_q + 16'd1;
        gap_d   = '0;
        state_d = (IDLE_GAP > 0) ? GAP : IDLE;
      end
      GAP: begin
        gap_d   = gap_q + 16'd1;
        state_d = (gap_q == GAP_LAST) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end
  assign tx          = tx_q;
  assign buf_read_en = rd_q;
  assign frame_done  = done_q;
  assign frame_count = cnt_q;
  assign busy        = state_q != IDLE;
endmodule
